// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, grant ids and rw encodings for mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;
  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; dcache wins ties unless MEM_ARB_RR_EN alternates them
//   ic_valid/dc_valid: pending requests; last (MEM_ARB_RR_EN only): owner of previous grant; dc_win: dcache granted
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic ic_valid,
  input  logic dc_valid,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`endif
  output logic dc_win
);
`ifdef MEM_ARB_RR_EN
  assign dc_win = dc_valid && (!ic_valid || last == GRANT_IC);
`else
  assign dc_win = dc_valid;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one burst memory port between icache and dcache line misses (MEM_ARB_RR_EN: round-robin ties)
//   ic_req_*/dc_req_*: line requests; ic_resp_*/dc_resp_*: registered read beats and dcache write-done pulse
//   dc_wdata/dc_wdata_next: dcache write beat stream; mem_*: memory command, write and read beat channels
//   busy: transaction in flight; grant_dc: current or last owner is the dcache
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_next,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              grant_dc
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OFF = $clog2(BEATS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'((64'd1 << OFF) - 64'd1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic rw, dc_win, grant, rd_beat, wr_beat, last;
  mem_arb_pick u_pick (
    .ic_valid(ic_req_valid),
    .dc_valid(dc_req_valid),
`ifdef MEM_ARB_RR_EN
    .last(grant_dc),
`endif
    .dc_win(dc_win)
  );
  // no grant while reset is held so nothing is handed out that the reset would drop
  assign grant = reset && state == IDLE && (ic_req_valid || dc_req_valid);
  assign rd_beat = state == RD && mem_resp_valid;
  assign wr_beat = state == WR && mem_wdata_ready;
  assign last = cnt == CW'(BEATS - 1);
  assign mem_req_addr = addr & MASK;
  assign mem_req_rw = rw;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state == IDLE ? (grant ? CMD : IDLE)
        : state == CMD ? (mem_req_ready ? (rw == MEM_WRITE ? WR : RD) : CMD)
        : ((rd_beat || wr_beat) && last) ? IDLE : state;
    ic_req_ready = grant && !dc_win;
    dc_req_ready = grant && dc_win;
    mem_req_valid = state == CMD;
    mem_wdata_valid = state == WR;
    mem_wdata = state == WR ? dc_wdata : '0;
    dc_wdata_next = wr_beat;
  end
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr <= '0;
      rw <= MEM_READ;
      grant_dc <= GRANT_IC;
      cnt <= '0;
      ic_resp_valid <= 1'b0;
      ic_resp_data <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data <= '0;
    end else begin
      if (grant) begin
        addr <= dc_win ? dc_req_addr : ic_req_addr;
        rw <= dc_win ? dc_req_rw : MEM_READ;
        grant_dc <= dc_win ? GRANT_DC : GRANT_IC;
      end
      if (state == CMD && mem_req_ready) cnt <= '0;
      else if (rd_beat || wr_beat) cnt <= last ? '0 : cnt + CW'(1);
      ic_resp_valid <= rd_beat && grant_dc == GRANT_IC;
      dc_resp_valid <= (rd_beat && grant_dc == GRANT_DC) || (wr_beat && last);
      if (rd_beat && grant_dc == GRANT_IC) ic_resp_data <= mem_resp_data;
      if (rd_beat && grant_dc == GRANT_DC) dc_resp_data <= mem_resp_data;
      else if (wr_beat && last) dc_resp_data <= '0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BEATS = 4;
  localparam int LINE_B = BEATS * DW / 8;
  logic clk, reset;
  logic ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_resp_data;
  logic dc_req_valid, dc_req_rw, dc_req_ready, dc_wdata_next, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_wdata, dc_resp_data;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_wdata, mem_resp_data;
  logic busy, grant_dc;
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_next(dc_wdata_next),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .grant_dc(grant_dc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  typedef struct {
    logic [DW-1:0] data;
    int unsigned at;
  } resp_t;
  resp_t ic_q[$];
  resp_t dc_q[$];
  always @(negedge clk) begin
    resp_t r;
    if (ic_q.size() > 0 && ic_q[0].at < cyc) begin
      r = ic_q.pop_front();
      chk("ic_resp_missing", 0, 1);
    end
    if (dc_q.size() > 0 && dc_q[0].at < cyc) begin
      r = dc_q.pop_front();
      chk("dc_resp_missing", 0, 1);
    end
    if (ic_resp_valid) begin
      if (ic_q.size() == 0) chk("ic_resp_unexpected", 1, 0);
      else begin
        r = ic_q.pop_front();
        chk("ic_resp_data", ic_resp_data, r.data);
        chk("ic_resp_cycle", cyc, r.at);
      end
    end
    if (dc_resp_valid) begin
      if (dc_q.size() == 0) chk("dc_resp_unexpected", 1, 0);
      else begin
        r = dc_q.pop_front();
        chk("dc_resp_data", dc_resp_data, r.data);
        chk("dc_resp_cycle", cyc, r.at);
      end
    end
  end
  logic ic_v, dc_v, dc_rw, own_dc, own_rw, active, cmd_done, exp_dc, can_grant, rst_prev, did_rst, n_reset;
  logic [AW-1:0] ic_a, dc_a, exp_addr;
  logic [DW-1:0] dc_line[BEATS];
  logic [DW-1:0] cur_line[BEATS];
  int beats, rst_hold;
  initial begin
    reset = 1'b0;
    {ic_req_valid, dc_req_valid, dc_req_rw, mem_req_ready, mem_wdata_ready, mem_resp_valid} = '0;
    ic_req_addr = '0;
    dc_req_addr = '0;
    dc_wdata = '0;
    mem_resp_data = '0;
    {ic_v, dc_v, dc_rw, own_dc, own_rw, active, cmd_done, did_rst} = '0;
    ic_a = '0;
    dc_a = '0;
    exp_addr = '0;
    beats = 0;
    rst_hold = 2;
    rst_prev = 1'b1;
    for (int c = 0; c < 2600; c++) begin
      @(negedge clk);
      if (rst_prev) begin
        chk("reset_outputs_zero", |{ic_resp_valid, ic_resp_data, dc_wdata_next, dc_resp_valid, dc_resp_data,
            mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata, busy, grant_dc}, 0);
        ic_q.delete();
        dc_q.delete();
        {active, cmd_done, own_dc, own_rw} = '0;
        beats = 0;
      end
`ifdef MEM_ARB_RR_EN
      exp_dc = dc_v && (!ic_v || !own_dc);
`else
      exp_dc = dc_v;
`endif
      can_grant = reset && !active && (ic_v || dc_v);
      chk("ic_req_ready", ic_req_ready, can_grant && !exp_dc);
      chk("dc_req_ready", dc_req_ready, can_grant && exp_dc);
      chk("busy", busy, active);
      chk("grant_dc", grant_dc, own_dc);
      chk("mem_req_valid", mem_req_valid, active && !cmd_done);
      if (active && !cmd_done) begin
        chk("mem_req_addr", mem_req_addr, exp_addr);
        chk("mem_req_rw", mem_req_rw, own_rw);
      end
      chk("mem_wdata_valid", mem_wdata_valid, active && cmd_done && own_rw);
      if (active && cmd_done && own_rw) begin
        chk("mem_wdata", mem_wdata, cur_line[beats]);
        chk("dc_wdata_next", dc_wdata_next, mem_wdata_ready);
      end else chk("dc_wdata_next_idle", dc_wdata_next, 0);
      if (reset) begin
        if (can_grant) begin
          active = 1'b1;
          cmd_done = 1'b0;
          beats = 0;
          own_dc = exp_dc;
          own_rw = exp_dc && dc_rw;
          exp_addr = exp_dc ? dc_a - (dc_a % LINE_B) : ic_a - (ic_a % LINE_B);
          if (exp_dc) begin
            cur_line = dc_line;
            dc_v = 1'b0;
          end else ic_v = 1'b0;
        end else if (active && !cmd_done) begin
          if (mem_req_ready) cmd_done = 1'b1;
        end else if (active && !own_rw) begin
          if (mem_resp_valid) begin
            if (own_dc) dc_q.push_back('{mem_resp_data, cyc + 1});
            else ic_q.push_back('{mem_resp_data, cyc + 1});
            beats++;
            if (beats == BEATS) active = 1'b0;
          end
        end else if (active && mem_wdata_ready) begin
          beats++;
          if (beats == BEATS) begin
            dc_q.push_back('{'0, cyc + 1});
            active = 1'b0;
          end
        end
      end
      rst_prev = !reset;
      if (c >= 60 && c < 2000 && active && cmd_done && !own_rw && beats == 2 &&
          (!did_rst || $urandom_range(0, 30) == 0)) begin
        did_rst = 1'b1;
        rst_hold = $urandom_range(1, 2);
        ic_v = 1'b0;
        dc_v = 1'b0;
      end
      n_reset = rst_hold == 0;
      if (rst_hold > 0) rst_hold--;
      if (c == 5) begin
        ic_v = 1'b1;
        ic_a = 32'h104;
      end
      if (c == 30) begin
        dc_v = 1'b1;
        dc_rw = 1'b1;
        dc_a = 32'h20C;
        foreach (dc_line[i]) dc_line[i] = $urandom;
      end
      if (n_reset && c >= 60 && c < 2300) begin
        if (!ic_v && (c >= 2000 || $urandom_range(0, 3) == 0)) begin
          ic_v = 1'b1;
          ic_a = $urandom;
        end
        if (!dc_v && (c >= 2000 || $urandom_range(0, 3) == 0)) begin
          dc_v = 1'b1;
          dc_rw = $urandom_range(0, 1);
          dc_a = $urandom;
          foreach (dc_line[i]) dc_line[i] = $urandom;
        end
      end
      @(posedge clk);
      #1;
      reset = n_reset;
      ic_req_valid = ic_v;
      ic_req_addr = ic_a;
      dc_req_valid = dc_v;
      dc_req_rw = dc_rw;
      dc_req_addr = dc_a;
      dc_wdata = beats < BEATS ? cur_line[beats] : '0;
      mem_req_ready = (c > 60 && c < 80) ? 1'b0 : 1'($urandom_range(0, 1));
      mem_resp_valid = $urandom_range(0, 2) != 0;
      mem_resp_data = $urandom;
      mem_wdata_ready = $urandom_range(0, 1);
    end
    @(negedge clk);
    chk("drain_idle", busy, 0);
    chk("drain_queues_empty", ic_q.size() + dc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
